// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI burst sequencer slice.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seq_state_t;

  // A beat may not be wider than the data bus.
  function automatic logic size_legal(input logic [2:0] size, input int data_width);
    int bytes_v;
    bytes_v = 32'sd1 << size;
    return (bytes_v <= (data_width / 32'sd8));
  endfunction

endpackage

// File: rtl/axi_addr.sv
// Next-beat address generator for FIXED/INCR/WRAP bursts.
module axi_addr
  import axi_pkg::*;
#(
  parameter logic ALIGN_ADDR = 1'b1,
  parameter int   ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  burst_t                burst,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step_s;
  logic [ADDR_WIDTH-1:0] aligned_s;
  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] wrap_mask_s;
  logic [ADDR_WIDTH-1:0] wrap_step_s;
  logic [ADDR_WIDTH-1:0] wrap_s;

  // Bytes per beat and the size-aligned copy of the current address.
  assign step_s    = ADDR_WIDTH'(1'b1) << size;
  assign aligned_s = cur_addr & ~(step_s - ADDR_WIDTH'(1'b1));

  // INCR advances from the aligned address when alignment is enabled; carry out drops.
  assign incr_s = (ALIGN_ADDR ? aligned_s : cur_addr) + step_s;

  // WRAP keeps the upper bits of the (len+1)*bytes window and wraps the low bits.
  assign wrap_mask_s = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1'b1)) << size) - ADDR_WIDTH'(1'b1);
  assign wrap_step_s = aligned_s + step_s;
  assign wrap_s      = (aligned_s & ~wrap_mask_s) | (wrap_step_s & wrap_mask_s);

  // Select the next address by burst type; reserved bursts never reach here but hold.
  always_comb begin
    next_addr = cur_addr;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_INCR:  next_addr = incr_s;
      BURST_WRAP:  next_addr = wrap_s;
      default:     next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_seq.sv
// Turns one AXI AR/AW request into a stream of per-beat addresses.
module axi_burst_seq
  import axi_pkg::*;
#(
  parameter logic ALIGN_ADDR = 1'b1,
  parameter int   ADDR_WIDTH = 12,
  parameter int   DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ax_valid,
  output logic                  ax_ready,
  input  logic [ADDR_WIDTH-1:0] ax_addr,
  input  logic [1:0]            ax_burst,
  input  logic [2:0]            ax_size,
  input  logic [7:0]            ax_len,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic                  busy,
  output logic                  cfg_err
);

  seq_state_t            state_r;
  seq_state_t            state_next_s;
  burst_t                burst_r;
  logic [2:0]            size_r;
  logic [7:0]            len_r;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [7:0]            idx_r;
  logic                  beat_last_r;
  logic                  ax_ready_r;
  logic                  cfg_err_r;
  logic                  accept_s;
  logic                  illegal_s;
  logic                  start_s;
  logic                  beat_fire_s;

  axi_addr #(
    .ALIGN_ADDR (ALIGN_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr (
    .cur_addr  (cur_addr_r),
    .burst     (burst_r),
    .size      (size_r),
    .len       (len_r),
    .next_addr (next_addr_s)
  );

  // Request classification: reserved burst, oversize beat, or bad wrap length.
  assign illegal_s = (ax_burst == 2'b11)
                   || !size_legal(ax_size, DATA_WIDTH)
                   || ((ax_burst == 2'b10) && !((ax_len == 8'd1) || (ax_len == 8'd3) ||
                                                (ax_len == 8'd7) || (ax_len == 8'd15)));

  assign accept_s    = ax_valid && ax_ready_r;
  assign start_s     = accept_s && !illegal_s;
  assign beat_fire_s = (state_r == BURST) && beat_ready;

  assign ax_ready   = ax_ready_r;
  assign cfg_err    = cfg_err_r;
  assign beat_valid = (state_r == BURST);
  assign busy       = (state_r == BURST);
  assign beat_addr  = cur_addr_r;
  assign beat_idx   = idx_r;
  assign beat_last  = beat_last_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state decode: start on a legal accept, finish on the last beat handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = BURST;
        else         state_next_s = IDLE;
      end
      BURST: begin
        if (beat_fire_s && beat_last_r) state_next_s = IDLE;
        else                            state_next_s = BURST;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake flags: ready only after a full idle cycle, error pulse for dropped requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_ready_r <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else begin
      ax_ready_r <= (state_r == IDLE) && !start_s;
      cfg_err_r  <= accept_s && illegal_s;
    end
  end

  // Burst datapath: latch the request, then step address and beat counter per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_r     <= BURST_FIXED;
      size_r      <= 3'd0;
      len_r       <= 8'd0;
      cur_addr_r  <= '0;
      idx_r       <= 8'd0;
      beat_last_r <= 1'b0;
    end else if (start_s) begin
      burst_r     <= burst_t'(ax_burst);
      size_r      <= ax_size;
      len_r       <= ax_len;
      cur_addr_r  <= ax_addr;
      idx_r       <= 8'd0;
      beat_last_r <= (ax_len == 8'd0);
    end else if (beat_fire_s) begin
      if (beat_last_r) begin
        beat_last_r <= 1'b0;
      end else begin
        cur_addr_r  <= next_addr_s;
        idx_r       <= idx_r + 8'd1;
        beat_last_r <= ((idx_r + 8'd1) == len_r);
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_seq.sv
// Self-checking bench for axi_burst_seq with a per-beat address model.
module tb_axi_burst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ax_valid;
  logic        ax_ready;
  logic [11:0] ax_addr;
  logic [1:0]  ax_burst;
  logic [2:0]  ax_size;
  logic [7:0]  ax_len;
  logic        beat_valid;
  logic        beat_ready;
  logic [11:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_addr[$];
  logic [7:0]  exp_idx[$];
  logic        exp_last[$];
  logic [11:0] hs_log[$];
  logic        last_log[$];
  logic [11:0] lit_q[$];

  axi_burst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .ax_valid   (ax_valid),
    .ax_ready   (ax_ready),
    .ax_addr    (ax_addr),
    .ax_burst   (ax_burst),
    .ax_size    (ax_size),
    .ax_len     (ax_len),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats from the burst rules, computed per index rather than by iteration.
  task automatic push_model(input int start, input int b, input int s, input int l);
    int bytes, win, base, al, a;
    bytes = 1 << s;
    win   = (l + 1) * bytes;
    base  = start - (start % win);
    al    = start - (start % bytes);
    for (int i = 0; i <= l; i++) begin
      if (i == 0 || b == 0) a = start;
      else if (b == 1)      a = (al + i * bytes) % 4096;
      else                  a = base + ((al - base + i * bytes) % win);
      exp_addr.push_back(a[11:0]);
      exp_idx.push_back(i[7:0]);
      exp_last.push_back(i == l);
    end
  endtask

  // Compare process: every presented beat must match the model head.
  always @(negedge clk) begin
    if (!rst && beat_valid) begin
      check("beat_expected", {31'd0, exp_addr.size() != 0}, 32'd1);
      check("busy_in_burst", {31'd0, busy}, 32'd1);
      check("ax_ready_in_burst", {31'd0, ax_ready}, 32'd0);
      if (exp_addr.size() != 0) begin
        check("beat_addr", {20'd0, beat_addr}, {20'd0, exp_addr[0]});
        check("beat_idx", {24'd0, beat_idx}, {24'd0, exp_idx[0]});
        check("beat_last", {31'd0, beat_last}, {31'd0, exp_last[0]});
        if (beat_ready) begin
          hs_log.push_back(beat_addr);
          last_log.push_back(beat_last);
          void'(exp_addr.pop_front());
          void'(exp_idx.pop_front());
          void'(exp_last.pop_front());
        end
      end
    end
  end

  task automatic send_req(input logic [11:0] a, input logic [1:0] b, input logic [2:0] s,
                          input logic [7:0] l, input bit legal);
    int n = 0;
    while (!ax_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ax_ready_wait", {31'd0, ax_ready}, 32'd1);
    ax_valid = 1'b1; ax_addr = a; ax_burst = b; ax_size = s; ax_len = l;
    if (legal) push_model(int'(a), int'(b), int'(s), int'(l));
    @(posedge clk); #1;
    ax_valid = 1'b0;
    check("cfg_err_after_req", {31'd0, cfg_err}, {31'd0, !legal});
    check("beat_valid_after_req", {31'd0, beat_valid}, {31'd0, legal});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_addr.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_addr.size(), 32'd0);
  endtask

  // Compare observed handshake addresses against a hand-written list.
  task automatic check_log(input string name);
    check({name, "_count"}, hs_log.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < hs_log.size(); i++)
      check(name, {20'd0, hs_log[i]}, {20'd0, lit_q[i]});
    hs_log.delete();
    last_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic pat[5];
    rst = 1'b1; ax_valid = 1'b0; ax_addr = 12'h0; ax_burst = 2'b00;
    ax_size = 3'd0; ax_len = 8'd0; beat_ready = 1'b1;
    #1;
    check("rst_ax_ready", {31'd0, ax_ready}, 32'd0);
    check("rst_beat_valid", {31'd0, beat_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_beat_last", {31'd0, beat_last}, 32'd0);
    check("rst_beat_addr", {20'd0, beat_addr}, 32'd0);
    check("rst_beat_idx", {24'd0, beat_idx}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // INCR aligned, full-rate, with end-of-burst timing.
    send_req(12'h000, 2'b01, 3'd2, 8'd3, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check("busy_after_last", {31'd0, busy}, 32'd0);
    check("ax_ready_bubble", {31'd0, ax_ready}, 32'd0);
    @(posedge clk); #1;
    check("ax_ready_after_bubble", {31'd0, ax_ready}, 32'd1);
    check("incr_last_flags", {28'd0, last_log[0], last_log[1], last_log[2], last_log[3]}, 32'h1);
    lit_q = '{12'h000, 12'h004, 12'h008, 12'h00C};
    check_log("incr_aligned");

    // INCR unaligned start.
    send_req(12'h007, 2'b01, 3'd2, 8'd3, 1'b1);
    wait_drain();
    lit_q = '{12'h007, 12'h008, 12'h00C, 12'h010};
    check_log("incr_unaligned");

    // WRAP within a 16-byte window.
    send_req(12'h004, 2'b10, 3'd2, 8'd3, 1'b1);
    wait_drain();
    check("wrap_last_flags", {28'd0, last_log[0], last_log[1], last_log[2], last_log[3]}, 32'h1);
    lit_q = '{12'h004, 12'h008, 12'h00C, 12'h000};
    check_log("wrap");

    // FIXED with beat_ready toggling.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    send_req(12'h010, 2'b00, 3'd2, 8'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      beat_ready = pat[k];
      @(posedge clk); #1;
      if (k == 1) check("stall_idx", {24'd0, beat_idx}, 32'd1);
    end
    beat_ready = 1'b1;
    check("fixed_done", {31'd0, busy}, 32'd0);
    lit_q = '{12'h010, 12'h010, 12'h010};
    check_log("fixed_stall");

    // Illegal requests are dropped with a single-cycle error pulse.
    send_req(12'h020, 2'b11, 3'd2, 8'd3, 1'b0);
    @(posedge clk); #1;
    check("cfg_err_pulse_rsvd", {31'd0, cfg_err}, 32'd0);
    send_req(12'h020, 2'b10, 3'd2, 8'd2, 1'b0);
    @(posedge clk); #1;
    check("cfg_err_pulse_wraplen", {31'd0, cfg_err}, 32'd0);
    send_req(12'h020, 2'b01, 3'd4, 8'd1, 1'b0);
    @(posedge clk); #1;
    check("cfg_err_pulse_size", {31'd0, beat_valid}, 32'd0);
    send_req(12'h100, 2'b01, 3'd3, 8'd1, 1'b1);
    wait_drain();
    lit_q = '{12'h100, 12'h108};
    check_log("incr_after_err");

    // Address space wrap and single-beat burst.
    send_req(12'hFFC, 2'b01, 3'd2, 8'd1, 1'b1);
    wait_drain();
    lit_q = '{12'hFFC, 12'h000};
    check_log("incr_wrap_top");
    send_req(12'h030, 2'b01, 3'd2, 8'd0, 1'b1);
    wait_drain();
    check("len0_last", {31'd0, last_log[0]}, 32'd1);
    lit_q = '{12'h030};
    check_log("len0");

    // Reset in the middle of a long burst.
    send_req(12'h200, 2'b01, 3'd2, 8'd7, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_idx", {24'd0, beat_idx}, 32'd1);
    rst = 1'b1;
    exp_addr.delete(); exp_idx.delete(); exp_last.delete();
    #1;
    check("mid_rst_beat_valid", {31'd0, beat_valid}, 32'd0);
    check("mid_rst_ax_ready", {31'd0, ax_ready}, 32'd0);
    check("mid_rst_idx", {24'd0, beat_idx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ax_ready", {31'd0, ax_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    hs_log.delete(); last_log.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
